adc_sample_sequencer: RTL
=========================

ADC_SAMPLE_SEQUENCER -- requirements
Module: adc_sample_sequencer

Interface
REQ-001 Parameter: DEPTH, 8, queue depth in samples (power of two, 2..64).
REQ-002 Parameter: TIMEOUT, 1024, max cycles to wait for engine completion (1..65535).
REQ-003 Port: i_clk  input  1  system clock; reset i_reset, synchronous, active-high; clock i_clk.
REQ-004 Port: i_reset  input  1  synchronous active-high reset.
REQ-005 Port: i_adc_valid  input  1  ADC sample strobe, one sample per high cycle.
REQ-006 Port: i_adc_data  input  21  signed two's-complement ADC count.
REQ-007 Port: o_x  output  21  sample presented to the correction engine, held stable between issues.
REQ-008 Port: o_srdyi  output  1  single-cycle issue strobe to the correction engine.
REQ-009 Port: i_srdyo  input  1  correction engine completion strobe.
REQ-010 Port: o_busy  output  1  high while a sample is in flight (ISSUE or WAIT).
REQ-011 Port: o_count  output  7  current queue occupancy, 0..DEPTH.
REQ-012 Port: o_overflow  output  1  sticky, set when a sample is dropped.
REQ-013 Port: o_drop_cnt  output  8  dropped-sample count, saturating at 255.
REQ-014 Port: o_timeout  output  1  sticky, set when TIMEOUT expires in WAIT.

Function
REQ-015 Push: i_adc_valid high and (o_count < DEPTH or a pop occurs in the same cycle) SHALL write i_adc_data at the tail.
REQ-016 Drop: i_adc_valid high, o_count == DEPTH and no same-cycle pop SHALL discard the sample, set o_overflow, and increment o_drop_cnt (saturating).
REQ-017 The FSM SHALL have states IDLE, ISSUE and WAIT.
REQ-018 IDLE: if the queue is non-empty, the FSM SHALL pop the head into o_x on that edge and go to ISSUE; otherwise it stays in IDLE.
REQ-019 ISSUE: o_srdyi SHALL be 1 for exactly this one cycle; the next state is WAIT unless i_srdyo is high, in which case the next state is IDLE.
REQ-020 WAIT: i_srdyo high SHALL return the FSM to IDLE; the wait counter increments every WAIT cycle.
REQ-021 WAIT timeout: the counter reaching TIMEOUT without i_srdyo SHALL set o_timeout and return the FSM to IDLE; the in-flight sample is abandoned.
REQ-022 i_srdyo in IDLE SHALL be ignored.
REQ-023 The wait counter SHALL clear on entry to ISSUE.
REQ-024 o_x SHALL change only on a pop edge.
REQ-025 Latency: a sample pushed at edge N into an empty queue with the FSM in IDLE SHALL produce o_srdyi=1 with o_x equal to that sample in the cycle after edge N+1 (2 edges).
REQ-026 Back-to-back issues: at least 2 cycles SHALL separate consecutive o_srdyi pulses; pops are strictly FIFO order.
REQ-027 Pointers SHALL wrap modulo DEPTH; o_count SHALL reflect simultaneous push+pop as unchanged.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 i_reset SHALL empty the queue, set the FSM to IDLE and clear the wait counter, with o_x=0, o_srdyi=0, o_busy=0, o_count=0, o_overflow=0, o_drop_cnt=0 and o_timeout=0.
REQ-030 Reset mid-WAIT SHALL abandon the in-flight sample; an i_srdyo pulse arriving afterwards in IDLE is ignored.
REQ-031 i_adc_valid SHALL be ignored in any cycle where i_reset is high.

Structure
REQ-032 The shared package nlc_pkg SHALL hold the ADC width (21), the FSM state enum, and the defaults for DEPTH and TIMEOUT.
REQ-033 Queue storage and pointers SHALL live in one sub-module, sync_fifo (parameterised width/depth; push, pop, full, empty, count); the FSM, counters and flags stay in the top.

Verification
REQ-034 Single sample: push 21'h1FFFFF (-1) into an idle, empty block -> o_srdyi pulses 2 edges later with o_x=21'h1FFFFF; i_srdyo 40 cycles later -> IDLE, o_busy=0.
REQ-035 Ordering: push -44978, 0, 44978 on consecutive cycles, each completed by i_srdyo 10 cycles after its issue -> o_x sequence -44978, 0, 44978; o_count peaks at 2.
REQ-036 Overflow: DEPTH=8, no i_srdyo, push 10 samples -> first sample in flight, 8 queued, 1 dropped -> o_overflow=1, o_drop_cnt=1.
REQ-037 Push at full with same-cycle pop -> sample accepted, o_count stays 8, o_drop_cnt unchanged.
REQ-038 Timeout: TIMEOUT=16, issue with no i_srdyo -> o_timeout=1 after 16 WAIT cycles; next queued sample issues next.
REQ-039 Reset mid-WAIT with 3 samples queued -> all outputs at their reset values next cycle; a later i_srdyo produces no o_srdyi.

Source files
------------

// File: rtl/nlc_pkg.sv
// rtl/nlc_pkg.sv - shared widths, FSM state type and parameter defaults for the ADC sequencer
//
// Purpose : common definitions imported by adc_sample_sequencer.
// Contents: ADC_W (sample width), state_e (IDLE/ISSUE/WAIT),
//           DEFAULT_DEPTH / DEFAULT_TIMEOUT parameter defaults.
package nlc_pkg;

  localparam int ADC_W           = 21;
  localparam int DEFAULT_DEPTH   = 8;
  localparam int DEFAULT_TIMEOUT = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count
//
// Purpose : sample queue storage and pointers for the ADC sequencer.
// Ports   : clk, reset (sync, active-high)
//           push/wdata  - write request; accepted when not full or popping
//           pop/rdata   - rdata is the current head; pop advances it
//           full, empty, count (0..DEPTH)
module sync_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A pop frees the head slot this edge, so a push at full is still accepted.
  assign do_push = push && (!full || do_pop);

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/adc_sample_sequencer.sv
// rtl/adc_sample_sequencer.sv - queues ADC samples and issues them one at a time to a correction engine
//
// Purpose : buffer ADC samples, hand each to the engine with a one-cycle
//           strobe, wait for completion or timeout, track drops.
// Ports   : i_clk, i_reset (sync, active-high)
//           i_adc_valid, i_adc_data  - incoming samples
//           o_x, o_srdyi             - sample and issue strobe to engine
//           i_srdyo                  - engine completion strobe
//           o_busy, o_count          - in-flight flag, queue occupancy
//           o_overflow, o_drop_cnt   - sticky drop flag, saturating drop count
//           o_timeout                - sticky engine timeout flag
module adc_sample_sequencer
  import nlc_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_adc_valid,
  input  logic [ADC_W-1:0] i_adc_data,
  output logic [ADC_W-1:0] o_x,
  output logic             o_srdyi,
  input  logic             i_srdyo,
  output logic             o_busy,
  output logic [6:0]       o_count,
  output logic             o_overflow,
  output logic [7:0]       o_drop_cnt,
  output logic             o_timeout
);

  localparam int AW = $clog2(DEPTH);

  state_e           state;
  logic [15:0]      wait_cnt;
  logic [ADC_W-1:0] fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic [AW:0]      fifo_count;
  logic             pop;
  logic             drop;

  assign pop  = (state == ST_IDLE) && !fifo_empty;
  assign drop = i_adc_valid && fifo_full && !pop;

  sync_fifo #(
    .WIDTH (ADC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .reset (i_reset),
    .push  (i_adc_valid),
    .wdata (i_adc_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // The FIFO count is itself a register, so this stays a registered output.
  assign o_count = 7'(fifo_count);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      o_x        <= '0;
      o_srdyi    <= 1'b0;
      o_busy     <= 1'b0;
      o_overflow <= 1'b0;
      o_drop_cnt <= '0;
      o_timeout  <= 1'b0;
    end else begin
      if (drop) begin
        o_overflow <= 1'b1;
        if (o_drop_cnt != 8'hFF) begin
          o_drop_cnt <= o_drop_cnt + 1'b1;
        end
      end

      case (state)
        ST_IDLE: begin
          // Engine completions arriving here belong to nothing and are ignored.
          if (pop) begin
            o_x      <= fifo_rdata;
            o_srdyi  <= 1'b1;
            o_busy   <= 1'b1;
            wait_cnt <= '0;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          o_srdyi <= 1'b0;
          if (i_srdyo) begin
            o_busy <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (i_srdyo) begin
            o_busy <= 1'b0;
            state  <= ST_IDLE;
          end else if (wait_cnt == 16'(TIMEOUT - 1)) begin
            // This is the TIMEOUT-th waiting cycle: abandon the sample.
            o_timeout <= 1'b1;
            o_busy    <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          o_srdyi <= 1'b0;
          o_busy  <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
